// File: rtl/memory_pkg.sv
// memory_pkg: shared store-path request type, queue port limit and popcount helper.
package memory_pkg;

  localparam int MEM_ADDR_W     = 32;
  localparam int MEM_DATA_W     = 32;
  localparam int MEMQ_MAX_PORTS = 8;
  localparam int MEMQ_NV_W      = $clog2(MEMQ_MAX_PORTS + 1);

  typedef struct packed {
    logic                  en;
    logic                  forcewrite;
    logic [MEM_ADDR_W-1:0] addr;
    logic [MEM_DATA_W-1:0] data;
  } write_req_pkt;

  // Number of requests with .en set; unused slots must be passed in as zero.
  function automatic logic [MEMQ_NV_W-1:0] popcount_en(input write_req_pkt reqs [MEMQ_MAX_PORTS]);
    logic [MEMQ_NV_W-1:0] cnt;
    cnt = {MEMQ_NV_W{1'b0}};
    for (int i = 0; i < MEMQ_MAX_PORTS; i++) begin
      cnt = cnt + {{(MEMQ_NV_W-1){1'b0}}, reqs[i].en};
    end
    return cnt;
  endfunction

endpackage

// File: rtl/mem_req_compactor.sv
// mem_req_compactor: packs sparse valid requests toward slot 0, keeping port order.
module mem_req_compactor
  import memory_pkg::*;
#(
  parameter int NUM_PORTS = 2
) (
  input  write_req_pkt         i_write_req [NUM_PORTS],
  output write_req_pkt         o_compacted [NUM_PORTS],
  output logic [MEMQ_NV_W-1:0] o_n_valid
);

  logic [MEMQ_NV_W-1:0] w_prefix [NUM_PORTS];
  write_req_pkt         w_padded [MEMQ_MAX_PORTS];

  // Prefix count: how many valid ports sit strictly below each port index.
  always_comb begin
    logic [MEMQ_NV_W-1:0] acc;
    acc = {MEMQ_NV_W{1'b0}};
    for (int i = 0; i < NUM_PORTS; i++) begin
      w_prefix[i] = acc;
      acc = acc + {{(MEMQ_NV_W-1){1'b0}}, i_write_req[i].en};
    end
  end

  // A valid port lands in the output slot equal to its prefix count.
  always_comb begin
    for (int j = 0; j < NUM_PORTS; j++) begin
      o_compacted[j] = '0;
      for (int i = j; i < NUM_PORTS; i++) begin
        if (i_write_req[i].en && (w_prefix[i] == MEMQ_NV_W'(j))) begin
          o_compacted[j] = i_write_req[i];
        end else begin
          o_compacted[j] = o_compacted[j];
        end
      end
    end
  end

  // Widen the request array to the package maximum so the shared popcount helper applies.
  always_comb begin
    for (int i = 0; i < MEMQ_MAX_PORTS; i++) begin
      w_padded[i] = '0;
    end
    for (int i = 0; i < NUM_PORTS; i++) begin
      w_padded[i] = i_write_req[i];
    end
  end

  assign o_n_valid = popcount_en(w_padded);

endmodule

// File: rtl/mem_write_queue.sv
// mem_write_queue: multi-port store-request FIFO feeding one memory bank write port.
// Enqueue is all-or-nothing; a pop in the same cycle frees one slot for the writers.
module mem_write_queue
  import memory_pkg::*;
#(
  parameter int NUM_PORTS    = 2,
  parameter int DEPTH        = 4,
  parameter int AFULL_THRESH = DEPTH - 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  write_req_pkt               i_write_req [NUM_PORTS],
  input  logic                       i_stall_back,
  input  logic                       i_stall_front,
  output write_req_pkt               o_membank_write_req,
  output logic                       o_stall_out,
  output logic [$clog2(DEPTH+1)-1:0] o_count,
  output logic                       o_almost_full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int CMP_W = ((CNT_W > MEMQ_NV_W) ? CNT_W : MEMQ_NV_W) + 1;

  write_req_pkt         r_mem [DEPTH];
  logic [PTR_W-1:0]     r_head;
  logic [PTR_W-1:0]     r_tail;
  logic [CNT_W-1:0]     r_count;

  write_req_pkt         w_compacted [NUM_PORTS];
  logic [MEMQ_NV_W-1:0] w_n_valid;
  logic                 w_pop;
  logic [CMP_W-1:0]     w_free;
  logic                 w_stall_out;
  logic                 w_enq;

  mem_req_compactor #(
    .NUM_PORTS (NUM_PORTS)
  ) u_compactor (
    .i_write_req (i_write_req),
    .o_compacted (w_compacted),
    .o_n_valid   (w_n_valid)
  );

  // Free space includes the slot vacated by this cycle's pop; stall_back is kept out
  // of stall_out so the upstream stall path stays loop-free.
  assign w_pop       = (r_count != {CNT_W{1'b0}}) & ~i_stall_front;
  assign w_free      = CMP_W'(DEPTH) - CMP_W'(r_count) + CMP_W'(w_pop);
  assign w_stall_out = CMP_W'(w_n_valid) > w_free;
  assign w_enq       = ~w_stall_out & ~i_stall_back & (w_n_valid != {MEMQ_NV_W{1'b0}});

  // Write the compacted requests into consecutive slots starting at the tail.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_enq) begin
      for (int k = 0; k < NUM_PORTS; k++) begin
        if (MEMQ_NV_W'(k) < w_n_valid) begin
          r_mem[r_tail + PTR_W'(k)] <= w_compacted[k];
        end
      end
    end
  end

  // Advance head on issue and tail on enqueue; pointers wrap at DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head  <= {PTR_W{1'b0}};
      r_tail  <= {PTR_W{1'b0}};
      r_count <= {CNT_W{1'b0}};
    end else begin
      if (w_pop) begin
        r_head <= r_head + PTR_W'(1'b1);
      end
      if (w_enq) begin
        r_tail <= r_tail + PTR_W'(w_n_valid);
      end
      r_count <= CNT_W'(CMP_W'(r_count)
                        + (w_enq ? CMP_W'(w_n_valid) : {CMP_W{1'b0}})
                        - CMP_W'(w_pop));
    end
  end

  // Present the head entry when occupied; an empty queue shows an all-zero request.
  always_comb begin
    if (r_count != {CNT_W{1'b0}}) begin
      o_membank_write_req = r_mem[r_head];
    end else begin
      o_membank_write_req = '0;
    end
  end

  assign o_stall_out   = w_stall_out;
  assign o_count       = r_count;
  assign o_almost_full = (r_count >= CNT_W'(AFULL_THRESH));

endmodule

// File: tb/tb_mem_write_queue.sv
// tb_mem_write_queue: directed vectors with a scoreboard of expected bank issues.
module tb_mem_write_queue;
  import memory_pkg::*;

  localparam int NP = 4;
  localparam int DP = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  write_req_pkt req [NP];
  logic         stall_back = 1'b0;
  logic         stall_front = 1'b0;
  write_req_pkt mbreq;
  logic         stall_out;
  logic [2:0]   count;
  logic         afull;

  int           n_vec = 0;
  int           n_err = 0;
  write_req_pkt sb_q [$];

  logic         prev_valid = 1'b0;
  logic [2:0]   prev_cnt = 3'd0;
  logic         prev_blk = 1'b0;
  logic         prev_pop = 1'b0;

  always #5 clk = ~clk;

  mem_write_queue #(
    .NUM_PORTS    (NP),
    .DEPTH        (DP),
    .AFULL_THRESH (DP - 1)
  ) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .i_write_req         (req),
    .i_stall_back        (stall_back),
    .i_stall_front       (stall_front),
    .o_membank_write_req (mbreq),
    .o_stall_out         (stall_out),
    .o_count             (count),
    .o_almost_full       (afull)
  );

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic write_req_pkt mkpkt(input logic [31:0] a);
    write_req_pkt p;
    p.en         = 1'b1;
    p.forcewrite = a[0];
    p.addr       = a;
    p.data       = a ^ 32'h5A5A_0000;
    return p;
  endfunction

  task automatic drive(input logic [3:0] en, input logic [31:0] a0, input logic [31:0] a1,
                       input logic [31:0] a2, input logic [31:0] a3,
                       input logic sb, input logic sf, input logic push);
    logic [31:0] a [NP];
    a[0] = a0; a[1] = a1; a[2] = a2; a[3] = a3;
    for (int p = 0; p < NP; p++) begin
      if (en[p]) req[p] = mkpkt(a[p]);
      else       req[p] = '0;
    end
    stall_back  = sb;
    stall_front = sf;
    if (push) begin
      for (int p = 0; p < NP; p++) begin
        if (en[p]) sb_q.push_back(req[p]);
      end
    end
  endtask

  // One clock: drive, check pre-edge state at negedge, step past the next rising edge.
  task automatic cyc(input string nm, input logic [3:0] en, input logic [31:0] a0,
                     input logic [31:0] a1, input logic [31:0] a2, input logic [31:0] a3,
                     input logic sb, input logic sf, input int exp_cnt,
                     input logic exp_stall, input logic exp_af);
    drive(en, a0, a1, a2, a3, sb, sf, !exp_stall && !sb);
    @(negedge clk);
    chk({nm, ".count"},     128'(count),     128'(exp_cnt));
    chk({nm, ".stall_out"}, 128'(stall_out), 128'(exp_stall));
    chk({nm, ".afull"},     128'(afull),     128'(exp_af));
    @(posedge clk);
    #1;
  endtask

  // Monitor: scoreboard pops on every issue, plus structural invariants.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_valid <= 1'b0;
    end else begin
      chk("inv.en_vs_count", 128'(mbreq.en), 128'(count != 3'd0));
      chk("inv.count_le_depth", 128'(count <= 3'd4), 128'(1'b1));
      if (prev_valid && prev_blk) begin
        chk("inv.no_enq_when_stalled", 128'(count), 128'(prev_cnt - 3'(prev_pop)));
      end
      if (mbreq.en && !stall_front) begin
        if (sb_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL issue.unexpected: got %0h expected no issue", mbreq);
        end else begin
          chk("issue", 128'(mbreq), 128'(sb_q.pop_front()));
        end
      end
      prev_valid <= 1'b1;
      prev_cnt   <= count;
      prev_blk   <= stall_out | stall_back;
      prev_pop   <= (count != 3'd0) && !stall_front;
    end
  end

  initial begin
    int         i;
    int         cycles;
    int         mcnt;
    logic       sf;
    logic       mpop;
    logic       st;
    int         free;

    for (int p = 0; p < NP; p++) req[p] = '0;

    // Reset then idle
    repeat (3) @(posedge clk);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    cyc("reset_idle", 4'b0000, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    chk("reset_idle.en", 128'(mbreq.en), 128'(1'b0));

    // Compaction: ports 1 and 3 valid, held in queue by stall_front
    cyc("compact", 4'b1010, 32'h0, 32'h10, 32'h0, 32'h30, 1'b0, 1'b1, 0, 1'b0, 1'b0);
    drive(4'b0000, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    chk("compact.count", 128'(count), 128'(2));
    chk("compact.head_addr", 128'(mbreq.addr), 128'(32'h10));
    @(posedge clk);
    #1;
    cyc("compact_d0", 4'b0000, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 2, 1'b0, 1'b0);
    cyc("compact_d1", 4'b0000, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1, 1'b0, 1'b0);
    cyc("compact_d2", 4'b0000, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 0, 1'b0, 1'b0);

    // Fill and backpressure
    cyc("fill0", 4'b0011, 32'h01, 32'h02, 32'h0, 32'h0, 1'b0, 1'b1, 0, 1'b0, 1'b0);
    cyc("fill1", 4'b0011, 32'h03, 32'h04, 32'h0, 32'h0, 1'b0, 1'b1, 2, 1'b0, 1'b0);
    cyc("full0", 4'b0001, 32'h05, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 4, 1'b1, 1'b1);
    cyc("full1", 4'b0001, 32'h05, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 4, 1'b1, 1'b1);

    // Pop credit: one fits while full, two do not
    cyc("credit1", 4'b0001, 32'hAA, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 4, 1'b0, 1'b1);
    cyc("credit2", 4'b0011, 32'hB1, 32'hB2, 32'h0, 32'h0, 1'b0, 1'b0, 4, 1'b1, 1'b1);
    cyc("drain0", 4'b0000, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 3, 1'b0, 1'b1);
    cyc("drain1", 4'b0000, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 2, 1'b0, 1'b0);
    cyc("drain2", 4'b0000, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1, 1'b0, 1'b0);
    cyc("drain3", 4'b0000, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 0, 1'b0, 1'b0);

    // stall_back blocks enqueue but does not raise stall_out
    cyc("sback", 4'b0001, 32'h77, 32'h0, 32'h0, 32'h0, 1'b1, 1'b1, 0, 1'b0, 1'b0);
    cyc("sback_after", 4'b0000, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 0, 1'b0, 1'b0);

    // Wrap-around: single writes 0..9, stall_front toggling, source retries on stall
    i = 0; cycles = 0; mcnt = 0; sf = 1'b0;
    while (i < 10 && cycles < 60) begin
      mpop = (mcnt > 0) && !sf;
      free = DP - mcnt + int'(mpop);
      st   = (free < 1);
      cyc($sformatf("wrap%0d", i), 4'b0001, 32'(i), 32'h0, 32'h0, 32'h0, 1'b0, sf,
          mcnt, st, (mcnt >= DP - 1));
      if (!st) begin
        i++;
        mcnt = mcnt + 1 - int'(mpop);
      end else begin
        mcnt = mcnt - int'(mpop);
      end
      sf = ~sf;
      cycles++;
    end
    if (i < 10) begin
      n_vec++;
      n_err++;
      $display("FAIL wrap.bound: got %0d writes expected 10", i);
    end
    for (int k = 0; k < 8 && mcnt > 0; k++) begin
      cyc("wrap_drain", 4'b0000, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, mcnt, 1'b0,
          (mcnt >= DP - 1));
      mcnt = mcnt - 1;
    end
    cyc("wrap_empty", 4'b0000, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 0, 1'b0, 1'b0);

    // Async reset mid-operation
    cyc("areset_fill", 4'b0111, 32'h41, 32'h42, 32'h43, 32'h0, 1'b0, 1'b1, 0, 1'b0, 1'b0);
    drive(4'b0000, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    chk("areset.count_before", 128'(count), 128'(3));
    #2 rst_n = 1'b0;
    #1;
    chk("areset.count", 128'(count), 128'(0));
    chk("areset.en", 128'(mbreq.en), 128'(1'b0));
    sb_q.delete();
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    cyc("areset_idle", 4'b0000, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 0, 1'b0, 1'b0);

    chk("sb.empty", 128'(sb_q.size()), 128'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
